// File: rtl/core_pkg.sv
// Shared RV32 core types: ALU/branch/memory encodings, opcode fields, ID->EX bundle.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASS2 = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_type_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_write;
        alu_op_t         alu_op;
        logic            alu_src1_pc;
        logic            alu_src2_imm;
        br_type_t        br_type;
        logic            jalr;
        logic            mem_read;
        logic            mem_write;
        mem_size_t       mem_size;
        logic            mem_unsigned;
        logic            illegal;
    } ex_bundle_t;

    // ALU op for OP / OP-IMM; alt selects SUB/SRA where funct7 allows it.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF->ID and ID->EX pipeline bundles; master is the producing stage.
interface id_pipe_if;
    import core_pkg::*;

    logic            valid;
    logic            ready;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;

    modport master (output valid, pc, instruction, input ready, flush);
    modport slave  (input valid, pc, instruction, output ready, flush);
endinterface

interface ex_pipe_if;
    import core_pkg::*;

    logic            valid;
    logic            ready;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rd_write;
    alu_op_t         alu_op;
    logic            alu_src1_pc;
    logic            alu_src2_imm;
    br_type_t        br_type;
    logic            jalr;
    logic            mem_read;
    logic            mem_write;
    mem_size_t       mem_size;
    logic            mem_unsigned;
    logic            illegal;

    modport master (
        output valid, pc, rs1_rdata, rs2_rdata, imm, rd, rd_write, alu_op,
               alu_src1_pc, alu_src2_imm, br_type, jalr, mem_read, mem_write,
               mem_size, mem_unsigned, illegal,
        input  ready, flush
    );
    modport slave (
        input  valid, pc, rs1_rdata, rs2_rdata, imm, rd, rd_write, alu_op,
               alu_src1_pc, alu_src2_imm, br_type, jalr, mem_read, mem_write,
               mem_size, mem_unsigned, illegal,
        output ready, flush
    );
endinterface

// File: rtl/id_stage_regfile.sv
// Integer register file: 2 combinational reads, 1 clocked write, x0 hardwired to zero.
module regfile
    import core_pkg::*;
#(
    parameter bit RF_WRITE_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_rdata,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_rdata,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem_q [32];
    logic [XLEN-1:0] mem_d [32];

    // Next contents: single write port, writes to x0 dropped.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read port 1 with optional same-cycle write bypass.
    always_comb begin
        rs1_rdata = '0;
        if (rs1_addr != '0) begin
            if (RF_WRITE_BYPASS && we && (waddr == rs1_addr)) rs1_rdata = wdata;
            else                                              rs1_rdata = mem_q[rs1_addr];
        end
    end

    // Read port 2 with optional same-cycle write bypass.
    always_comb begin
        rs2_rdata = '0;
        if (rs2_addr != '0) begin
            if (RF_WRITE_BYPASS && we && (waddr == rs2_addr)) rs2_rdata = wdata;
            else                                              rs2_rdata = mem_q[rs2_addr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, register read, RAW interlock, registered bundle to EX.
module id_stage
    import core_pkg::*;
#(
    parameter bit RF_WRITE_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_b,
    id_pipe_if.slave        id_pipe,
    ex_pipe_if.master       ex_pipe,
    input  logic            ex_hz_rd_write,
    input  logic [4:0]      ex_hz_rd,
    input  logic            mem_hz_rd_write,
    input  logic [4:0]      mem_hz_rd,
    input  logic            wb_rf_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_rd_wdata
);

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_rdata, rs2_rdata;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic            rs1_used, rs2_used, rd_wr, illegal;
    logic            rs1_hz, rs2_hz, hazard, fire;
    ex_bundle_t      dec;

    logic            ex_valid_q, ex_valid_d;
    ex_bundle_t      bundle_q, bundle_d;

    assign instr    = id_pipe.instruction;
    assign opcode   = instr[6:0];
    assign rd_addr  = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign funct7   = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    regfile #(
        .RF_WRITE_BYPASS(RF_WRITE_BYPASS)
    ) u_regfile (
        .clk      (clk),
        .rs1_addr (rs1_addr),
        .rs1_rdata(rs1_rdata),
        .rs2_addr (rs2_addr),
        .rs2_rdata(rs2_rdata),
        .we       (wb_rf_write),
        .waddr    (wb_rd),
        .wdata    (wb_rd_wdata)
    );

    // Instruction decode into the EX bundle, plus register-use flags for the interlock.
    always_comb begin
        dec          = '0;
        dec.alu_op   = ALU_ADD;
        dec.br_type  = BR_NONE;
        dec.mem_size = MEM_B;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        rd_wr        = 1'b0;
        illegal      = 1'b0;

        case (opcode)
            OPC_LUI: begin
                rd_wr            = 1'b1;
                dec.imm          = imm_u;
                dec.alu_op       = ALU_PASS2;
                dec.alu_src2_imm = 1'b1;
            end
            OPC_AUIPC: begin
                rd_wr            = 1'b1;
                dec.imm          = imm_u;
                dec.alu_src1_pc  = 1'b1;
                dec.alu_src2_imm = 1'b1;
            end
            OPC_JAL: begin
                rd_wr            = 1'b1;
                dec.imm          = imm_j;
                dec.alu_src1_pc  = 1'b1;
                dec.alu_src2_imm = 1'b1;
                dec.br_type      = BR_JUMP;
            end
            OPC_JALR: begin
                rd_wr            = 1'b1;
                rs1_used         = 1'b1;
                dec.imm          = imm_i;
                dec.alu_src2_imm = 1'b1;
                dec.br_type      = BR_JUMP;
                dec.jalr         = 1'b1;
                illegal          = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                rs1_used         = 1'b1;
                rs2_used         = 1'b1;
                dec.imm          = imm_b;
                dec.alu_src1_pc  = 1'b1;
                dec.alu_src2_imm = 1'b1;
                case (funct3)
                    F3_BEQ:  dec.br_type = BR_EQ;
                    F3_BNE:  dec.br_type = BR_NE;
                    F3_BLT:  dec.br_type = BR_LT;
                    F3_BGE:  dec.br_type = BR_GE;
                    F3_BLTU: dec.br_type = BR_LTU;
                    F3_BGEU: dec.br_type = BR_GEU;
                    default: illegal     = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                rd_wr            = 1'b1;
                rs1_used         = 1'b1;
                dec.imm          = imm_i;
                dec.alu_src2_imm = 1'b1;
                dec.mem_read     = 1'b1;
                dec.mem_size     = mem_size_t'(funct3[1:0]);
                dec.mem_unsigned = funct3[2];
                illegal          = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
            end
            OPC_STORE: begin
                rs1_used         = 1'b1;
                rs2_used         = 1'b1;
                dec.imm          = imm_s;
                dec.alu_src2_imm = 1'b1;
                dec.mem_write    = 1'b1;
                dec.mem_size     = mem_size_t'(funct3[1:0]);
                illegal          = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                rd_wr            = 1'b1;
                rs1_used         = 1'b1;
                dec.imm          = imm_i;
                dec.alu_src2_imm = 1'b1;
                dec.alu_op       = alu_from_f3(funct3, (funct3 == F3_SR) && instr[30]);
                if (funct3 == F3_SLL)     illegal = (funct7 != F7_BASE);
                else if (funct3 == F3_SR) illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                rd_wr      = 1'b1;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                dec.alu_op = alu_from_f3(funct3, instr[30]);
                illegal    = !((funct7 == F7_BASE) ||
                               ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
            end
            OPC_MISC_MEM: begin
                illegal = (funct3 != 3'b000);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (illegal) begin
            rd_wr         = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
        end

        dec.pc        = id_pipe.pc;
        dec.rs1_rdata = rs1_rdata;
        dec.rs2_rdata = rs2_rdata;
        dec.rd        = rd_addr;
        dec.rd_write  = rd_wr && (rd_addr != '0);
        dec.illegal   = illegal;
    end

    // RAW interlock against EX/MEM producers; WB matches are covered by the regfile bypass.
    always_comb begin
        rs1_hz = rs1_used && (rs1_addr != '0) &&
                 ((ex_hz_rd_write && (ex_hz_rd == rs1_addr)) ||
                  (mem_hz_rd_write && (mem_hz_rd == rs1_addr)));
        rs2_hz = rs2_used && (rs2_addr != '0) &&
                 ((ex_hz_rd_write && (ex_hz_rd == rs2_addr)) ||
                  (mem_hz_rd_write && (mem_hz_rd == rs2_addr)));
        hazard = id_pipe.valid && (rs1_hz || rs2_hz);
        fire   = id_pipe.valid && !hazard && ex_pipe.ready;
    end

    assign id_pipe.ready = !id_pipe.valid || fire;
    assign id_pipe.flush = ex_pipe.flush;

    // Next EX valid (flush beats everything) and payload capture on fire.
    always_comb begin
        ex_valid_d = ex_valid_q;
        if (ex_pipe.flush)      ex_valid_d = 1'b0;
        else if (ex_pipe.ready) ex_valid_d = fire;
        bundle_d = fire ? dec : bundle_q;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            ex_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    assign ex_pipe.valid        = ex_valid_q;
    assign ex_pipe.pc           = bundle_q.pc;
    assign ex_pipe.rs1_rdata    = bundle_q.rs1_rdata;
    assign ex_pipe.rs2_rdata    = bundle_q.rs2_rdata;
    assign ex_pipe.imm          = bundle_q.imm;
    assign ex_pipe.rd           = bundle_q.rd;
    assign ex_pipe.rd_write     = bundle_q.rd_write;
    assign ex_pipe.alu_op       = bundle_q.alu_op;
    assign ex_pipe.alu_src1_pc  = bundle_q.alu_src1_pc;
    assign ex_pipe.alu_src2_imm = bundle_q.alu_src2_imm;
    assign ex_pipe.br_type      = bundle_q.br_type;
    assign ex_pipe.jalr         = bundle_q.jalr;
    assign ex_pipe.mem_read     = bundle_q.mem_read;
    assign ex_pipe.mem_write    = bundle_q.mem_write;
    assign ex_pipe.mem_size     = bundle_q.mem_size;
    assign ex_pipe.mem_unsigned = bundle_q.mem_unsigned;
    assign ex_pipe.illegal      = bundle_q.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction Decode stage of the RV32 in-order core. It sits directly downstream of the IF stage and consumes its registered PC/instruction pipeline. It decodes RV32I, reads the integer register file, interlocks on RAW hazards, and delivers a registered decode bundle to EX. It also relays EX's redirect flush back to IF.

## Interface
Widths use `` `XLEN`` (=32) from `config.svh`.

Parameters:
- RF_WRITE_BYPASS, 1, when 1, a WB write to the register being read in the same cycle returns the new data.

Ports:
- clk  in  1  core clock
- rst_b  in  1  synchronous, active-high reset
- id_pipe_valid  in  1  IF→ID bundle valid
- id_pipe_ready  out  1  ID accepts IF bundle this cycle
- id_pipe_flush  out  1  flush to IF
- id_pipe_pc  in  XLEN  instruction PC
- id_pipe_instruction  in  XLEN  instruction word
- ex_pipe_valid  out  1  ID→EX bundle valid
- ex_pipe_ready  in  1  EX accepts bundle
- ex_pipe_flush  in  1  EX redirect (jump or taken branch)
- ex_pipe_pc  out  XLEN  PC
- ex_pipe_rs1_rdata, ex_pipe_rs2_rdata  out  XLEN  operands
- ex_pipe_imm  out  XLEN  sign-extended immediate
- ex_pipe_rd  out  5  destination register
- ex_pipe_rd_write  out  1  writes rd (forced 0 when rd==0)
- ex_pipe_alu_op  out  4  alu_op_t
- ex_pipe_alu_src1_pc, ex_pipe_alu_src2_imm  out  1  operand selects
- ex_pipe_br_type  out  3  br_type_t (NONE/EQ/NE/LT/GE/LTU/GEU/JUMP)
- ex_pipe_jalr  out  1  target = rs1+imm with bit 0 cleared
- ex_pipe_mem_read, ex_pipe_mem_write  out  1  load/store
- ex_pipe_mem_size  out  2  byte/half/word
- ex_pipe_mem_unsigned  out  1  LBU/LHU
- ex_pipe_illegal  out  1  undecodable opcode/funct
- ex_hz_rd_write, mem_hz_rd_write  in  1  EX/MEM instruction writes rd
- ex_hz_rd, mem_hz_rd  in  5  EX/MEM destination
- wb_rf_write  in  1  WB write enable
- wb_rd  in  5  WB destination
- wb_rd_wdata  in  XLEN  WB data

## Operation
- Register file: 32×XLEN, two combinational read ports, one write port on clk. x0 reads 0. Writes to x0 are ignored. Contents are not reset.
- Decode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. FENCE decodes as NOP (rd_write=0). ECALL, EBREAK and all other encodings set illegal=1 and clear rd_write, mem_read and mem_write.
- Immediates: I/S/B/U/J formats, sign-extended to XLEN. B and J immediates have bit 0 = 0.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used by BRANCH, STORE and OP.
- hazard = id_pipe_valid & any used rs≠0 matching (ex_hz_rd with ex_hz_rd_write) or (mem_hz_rd with mem_hz_rd_write). There is no forwarding. A WB match is resolved by the bypass.
- fire = id_pipe_valid & ~hazard & ex_pipe_ready.
- id_pipe_ready = ~id_pipe_valid | fire.
- id_pipe_flush = ex_pipe_flush (combinational).
- ex_pipe_valid update, in priority order:
  - reset → 0
  - ex_pipe_flush → 0
  - ex_pipe_ready → fire
  - otherwise hold
- Payload registers load on fire, and otherwise hold.

## Timing
- Decode, register read and hazard check are combinational in the ID cycle. The bundle appears on ex_pipe_* one clk after fire (latency 1).
- Reset: ex_pipe_valid=0 and all ex_pipe_* payload=0. id_pipe_ready and id_pipe_flush follow their equations.
- Hazard: each stalled cycle inserts one bubble into EX (ex_pipe_valid=0 when ex_pipe_ready=1). The IF bundle is held because id_pipe_ready=0.
- Simultaneous flush and fire: the flush wins, EX receives valid=0, and the ID instruction is discarded because IF drops its valid.
- EX backpressure (ex_pipe_ready=0): ex_pipe_* hold, id_pipe_ready=0.
- WB write and read of the same register in the same cycle: new data with RF_WRITE_BYPASS=1, old data with 0.

## Structure
- Shared `core_pkg`: alu_op_t, br_type_t, mem_size_t, and opcode/funct3/funct7 localparams. EX uses the same package.
- One sub-module, `regfile` (2R1W, x0 hardwired, bypass parameter). The decoder and hazard logic stay inline.

## Test plan
- Reset, then IF presents ADDI x1,x0,5 (0x00500093) at pc 0x0 → next cycle ex_pipe_valid=1, rd=1, rd_write=1, imm=5, alu_src2_imm=1.
- WB writes x2=0xDEADBEEF while ADD x3,x2,x2 is decoded in the same cycle → rs1_rdata=rs2_rdata=0xDEADBEEF; with RF_WRITE_BYPASS=0 the operands are the old value.
- ex_hz_rd=2 with ex_hz_rd_write=1, and ID holds SW x2,0(x1) → id_pipe_ready=0 and a bubble goes to EX. When ex_hz_rd_write drops, the store issues the following cycle.
- BEQ with offset −4 → imm=0xFFFFFFFC, br_type=EQ, rd_write=0.
- ex_pipe_flush asserted during fire → id_pipe_flush=1, and ex_pipe_valid=0 next cycle.
- Instruction 0x00000073 (ECALL) → illegal=1, rd_write=0, mem_read=0, mem_write=0.
